// File: rtl/disp_arbiter.sv
// Round-robin display arbiter: grants one of four requesters to the display
// scanner and holds that grant for a minimum dwell measured in tick_en pulses.
module disp_arbiter #(
    parameter int unsigned DWELL = 190
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        tick_en,
    input  logic [3:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic [15:0] data2,
    input  logic [15:0] data3,
    input  logic        lock,
    output logic [15:0] disp_data,
    output logic [3:0]  grant,
    output logic        busy
);

    localparam logic [15:0] DWELL_M1 = 16'(DWELL - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  last, last_nx;
    logic [15:0] dcnt, dcnt_nx;
    logic [15:0] disp_nx;
    logic [3:0]  grant_nx;
    logic        busy_nx;

    logic [15:0] data_arr [4];
    logic [1:0]  rr_idx;
    logic        rr_hit;

    assign data_arr[0] = data0;
    assign data_arr[1] = data1;
    assign data_arr[2] = data2;
    assign data_arr[3] = data3;

    // Search starts at last+1 and wraps; the fourth candidate is last itself,
    // so a lone current requester keeps its grant.
    always_comb begin
        rr_idx = last;
        rr_hit = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!rr_hit && req[last + 2'(i)]) begin
                rr_idx = last + 2'(i);
                rr_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        last_nx  = last;
        dcnt_nx  = dcnt;
        grant_nx = grant;
        busy_nx  = busy;
        disp_nx  = disp_data;
        case (state)
            IDLE: begin
                grant_nx = 4'b0000;
                busy_nx  = 1'b0;
                if (rr_hit) begin
                    state_nx = HOLD;
                    last_nx  = rr_idx;
                    grant_nx = 4'b0001 << rr_idx;
                    busy_nx  = 1'b1;
                    dcnt_nx  = DWELL_M1;
                    disp_nx  = data_arr[rr_idx];
                end
            end
            HOLD: begin
                disp_nx = data_arr[last];
                if (tick_en) begin
                    if (dcnt != 16'd0) begin
                        dcnt_nx = dcnt - 16'd1;
                    end else if (lock) begin
                        dcnt_nx = DWELL_M1;
                    end else if (rr_hit) begin
                        last_nx  = rr_idx;
                        grant_nx = 4'b0001 << rr_idx;
                        dcnt_nx  = DWELL_M1;
                        disp_nx  = data_arr[rr_idx];
                    end else begin
                        // Nobody left asking: drop the grant, keep the last shown value.
                        state_nx = IDLE;
                        grant_nx = 4'b0000;
                        busy_nx  = 1'b0;
                        disp_nx  = disp_data;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = 4'b0000;
                busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            last      <= 2'd3;
            dcnt      <= 16'd0;
            grant     <= 4'b0000;
            busy      <= 1'b0;
            disp_data <= 16'h0000;
        end else begin
            state     <= state_nx;
            last      <= last_nx;
            dcnt      <= dcnt_nx;
            grant     <= grant_nx;
            busy      <= busy_nx;
            disp_data <= disp_nx;
        end
    end

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed bench for disp_arbiter: one DUT with DWELL=3 for the main sequence
// and a second with DWELL=1 for the every-tick-expires case.
module tb_disp_arbiter;

    logic        clk;
    logic        clr;
    logic        tick_en;
    logic [3:0]  req;
    logic [15:0] data0, data1, data2, data3;
    logic        lock;
    logic [15:0] disp_data, dd1;
    logic [3:0]  grant, g1;
    logic        busy, b1;

    int n_checks = 0;
    int n_fail   = 0;

    disp_arbiter #(.DWELL(3)) dut (
        .clk(clk), .clr(clr), .tick_en(tick_en), .req(req),
        .data0(data0), .data1(data1), .data2(data2), .data3(data3),
        .lock(lock), .disp_data(disp_data), .grant(grant), .busy(busy)
    );

    disp_arbiter #(.DWELL(1)) dut1 (
        .clk(clk), .clr(clr), .tick_en(tick_en), .req(req),
        .data0(data0), .data1(data1), .data2(data2), .data3(data3),
        .lock(lock), .disp_data(dd1), .grant(g1), .busy(b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1ns after the edge and check grant/busy consistency.
    task automatic step();
        @(posedge clk);
        #1;
        chk("grant_consistent", 32'($onehot0(grant) && ((grant != 4'b0000) == busy)), 32'd1);
        chk("grant1_consistent", 32'($onehot0(g1) && ((g1 != 4'b0000) == b1)), 32'd1);
    endtask

    task automatic tick();
        tick_en = 1'b1;
        step();
        tick_en = 1'b0;
    endtask

    logic [3:0] cur, nxt;

    initial begin
        clr = 1'b1; tick_en = 1'b0; req = 4'b0000; lock = 1'b0;
        data0 = 16'haaaa; data1 = 16'h1234; data2 = 16'hbbbb; data3 = 16'hcccc;
        step(); step();
        clr = 1'b0;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_disp", 32'(disp_data), 32'h0);
        chk("rst_grant1", 32'(g1), 32'h0);

        // First grant after reset, index 0 not requesting -> index 1
        req = 4'b1010;
        step();
        chk("first_grant", 32'(grant), 32'h2);
        chk("first_busy", 32'(busy), 32'h1);
        chk("first_disp", 32'(disp_data), 32'h1234);

        // Rotation between 0 and 1, three ticks per dwell, idle cycles ignored
        clr = 1'b1; step(); clr = 1'b0;
        req = 4'b0011;
        step();
        chk("rot_entry", 32'(grant), 32'h1);
        cur = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            nxt = (cur == 4'b0001) ? 4'b0010 : 4'b0001;
            tick();
            chk("rot_tick1", 32'(grant), 32'(cur));
            step();
            chk("rot_notick", 32'(grant), 32'(cur));
            tick();
            chk("rot_tick2", 32'(grant), 32'(cur));
            tick();
            chk("rot_tick3", 32'(grant), 32'(nxt));
            cur = nxt;
        end

        // Granted requester drops early; dwell still runs to completion
        clr = 1'b1; step(); clr = 1'b0;
        req = 4'b0100;
        step();
        chk("drop_grant", 32'(grant), 32'h4);
        chk("drop_disp", 32'(disp_data), 32'hbbbb);
        tick();
        req = 4'b0000;
        tick();
        chk("drop_hold_grant", 32'(grant), 32'h4);
        chk("drop_hold_busy", 32'(busy), 32'h1);
        tick();
        chk("drop_idle_grant", 32'(grant), 32'h0);
        chk("drop_idle_busy", 32'(busy), 32'h0);
        chk("drop_idle_disp", 32'(disp_data), 32'hbbbb);
        step();
        chk("idle_keep_disp", 32'(disp_data), 32'hbbbb);

        // disp_data follows data2 with one cycle latency, ignores others
        req = 4'b0100;
        step();
        chk("follow_grant", 32'(grant), 32'h4);
        data2 = 16'h5678;
        #0;
        chk("follow_before", 32'(disp_data), 32'hbbbb);
        step();
        chk("follow_after", 32'(disp_data), 32'h5678);
        data0 = 16'h0f0f; data1 = 16'h1111; data3 = 16'h3333;
        step();
        chk("follow_other", 32'(disp_data), 32'h5678);

        // clr mid-HOLD (dcnt=2) wins over req; next grant favours index 0
        clr = 1'b1; req = 4'b1111;
        step();
        clr = 1'b0;
        chk("midclr_grant", 32'(grant), 32'h0);
        chk("midclr_busy", 32'(busy), 32'h0);
        chk("midclr_disp", 32'(disp_data), 32'h0);
        step();
        chk("postclr_grant", 32'(grant), 32'h1);
        chk("postclr_disp", 32'(disp_data), 32'h0f0f);

        // lock freezes rotation across ten expiries
        lock = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick(); tick(); tick();
            chk("lock_hold", 32'(grant), 32'h1);
        end
        lock = 1'b0;
        tick(); tick();
        chk("unlock_pre", 32'(grant), 32'h1);
        tick();
        chk("unlock_adv", 32'(grant), 32'h2);

        // req change on the expiry cycle itself is what gets arbitrated
        tick(); tick();
        req = 4'b1000;
        tick();
        chk("coincident_grant", 32'(grant), 32'h8);
        chk("coincident_disp", 32'(disp_data), 32'h3333);

        // Only the current requester left: grant stays through expiry
        tick(); tick(); tick();
        chk("solo_grant", 32'(grant), 32'h8);
        chk("solo_busy", 32'(busy), 32'h1);

        // DWELL=1: every tick in HOLD is an expiry
        clr = 1'b1; step(); clr = 1'b0;
        req = 4'b0011;
        step();
        chk("d1_entry", 32'(g1), 32'h1);
        step();
        chk("d1_notick", 32'(g1), 32'h1);
        tick();
        chk("d1_tick1", 32'(g1), 32'h2);
        chk("d3_tick1", 32'(grant), 32'h1);
        tick();
        chk("d1_tick2", 32'(g1), 32'h1);
        chk("d1_disp", 32'(dd1), 32'h0f0f);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
